uart_receiver: RTL and testbench

Serial receive side of the board UART: an 8N1 receiver with a small byte FIFO, exposed to the core as two memory-mapped registers. It samples the `uart_rx` pin and captures received bytes. The core polls a status register and pops bytes through a data register on the shared data-memory bus. The top level muxes `mmio_rdata` into the core's read path whenever `mmio_hit` is high.

---
 rtl/uart_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 serial receiver with a small byte FIFO, read by the core through two
// memory-mapped registers (DATA pops a byte, STATUS reports flags).
module uart_receiver #(
    parameter int          CLOCK_HZ    = 27000000,
    parameter int          BAUD        = 115200,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DATA_ADDR   = 16'hF010,
    parameter logic [15:0] STATUS_ADDR = 16'hF011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic [15:0] mmio_addr,
    input  logic        mmio_read,
    output logic [7:0]  mmio_rdata,
    output logic        mmio_hit,
    output logic        rx_valid
);

    localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
    // Counter only ever holds values up to CLKS_PER_BIT-1.
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    localparam logic [CW-1:0]   HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic            rx_meta_reg;
    logic            rxs_reg;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      idx_reg, idx_next;
    logic [7:0]      shift_reg, shift_next;
    logic            push;
    logic            frame_err;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic            ferr_reg, ovr_reg;

    logic            empty, full;
    logic            data_rd, status_rd;
    logic            pop, push_ok, overrun;
    logic [7:0]      status;

    // Two-flop synchronizer for the asynchronous pin; idles high out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
        end
    end

    // Receive FSM state and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
        end
    end

    // Next-state logic: mid-bit sampling driven by a down-counter that expires at zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        push       = 1'b0;
        frame_err  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rxs_reg) begin
                    cnt_next   = HALF_LOAD;
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == '0) begin
                    if (rxs_reg) begin
                        // Line went back high before mid-start: glitch, ignore it.
                        state_next = IDLE;
                    end else begin
                        cnt_next   = FULL_LOAD;
                        idx_next   = 3'd0;
                        state_next = DATA;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    shift_next[idx_reg] = rxs_reg;
                    cnt_next            = FULL_LOAD;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == '0) begin
                    if (rxs_reg) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        // Low stop bit: drop the byte and wait out any break.
                        frame_err  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rxs_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus decode and FIFO handshake; a pop frees a slot for a same-cycle push.
    always_comb begin
        empty     = (count_reg == '0);
        full      = (count_reg == DEPTH_CNT);
        data_rd   = mmio_read && (mmio_addr == DATA_ADDR);
        status_rd = mmio_read && (mmio_addr == STATUS_ADDR);
        pop       = data_rd && !empty;
        push_ok   = push && (!full || pop);
        overrun   = push && !push_ok;
        status    = {4'b0000, ferr_reg, ovr_reg, full, !empty};
    end

    // FIFO storage write port.
    always_ff @(posedge clock) begin
        if (reset && push_ok) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky error flags: a status read clears them, but a new event in the same cycle wins.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ferr_reg <= 1'b0;
            ovr_reg  <= 1'b0;
        end else begin
            ferr_reg <= frame_err | (ferr_reg & !status_rd);
            ovr_reg  <= overrun   | (ovr_reg  & !status_rd);
        end
    end

    // Registered read port: one-cycle latency, data holds when not addressed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mmio_rdata <= 8'h00;
            mmio_hit   <= 1'b0;
        end else if (data_rd) begin
            mmio_rdata <= empty ? 8'h00 : mem[rd_ptr_reg];
            mmio_hit   <= 1'b1;
        end else if (status_rd) begin
            mmio_rdata <= status;
            mmio_hit   <= 1'b1;
        end else begin
            mmio_hit   <= 1'b0;
        end
    end

    assign rx_valid = !empty;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of single frames plus
// hand-written multi-cycle sequences, with a byte scoreboard queue.
module tb_uart_receiver;

    localparam int          CPB         = 16;
    localparam int          DEPTH       = 4;
    localparam logic [15:0] DATA_ADDR   = 16'hF010;
    localparam logic [15:0] STATUS_ADDR = 16'hF011;
    localparam int          STOP_CYC    = 9 * CPB + CPB / 2 + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] mmio_addr = 16'h0000;
    logic        mmio_read = 1'b0;
    logic [7:0]  mmio_rdata;
    logic        mmio_hit;
    logic        rx_valid;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] status;
    } vec_t;
    vec_t vecs[7];

    uart_receiver #(
        .CLOCK_HZ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH),
        .DATA_ADDR  (DATA_ADDR),
        .STATUS_ADDR(STATUS_ADDR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .mmio_addr (mmio_addr),
        .mmio_read (mmio_read),
        .mmio_rdata(mmio_rdata),
        .mmio_hit  (mmio_hit),
        .rx_valid  (rx_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int cyc);
        int b;
        b = cyc / CPB;
        if (b == 0) return 1'b0;
        else if (b <= 8) return d[b-1];
        else if (b == 9) return stop;
        else return 1'b1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            mmio_read = 1'b0;
        end
    endtask

    // Sends one frame; optionally strobes a DATA read at cycle rd_cycle.
    task automatic run_frame(input logic [7:0] d, input logic stop, input int rd_cycle, input string name);
        logic [7:0] rd_req;
        rd_req = 8'h00;
        for (int cyc = 0; cyc < 10 * CPB; cyc++) begin
            @(posedge clock); #1;
            rx        = frame_bit(d, stop, cyc);
            mmio_addr = DATA_ADDR;
            mmio_read = (cyc == rd_cycle);
            @(negedge clock);
            if (cyc == STOP_CYC)
                check({name, " rx_valid@stop"}, {7'b0, rx_valid}, {7'b0, exp_q.size() != 0});
            if (cyc == rd_cycle) begin
                if (exp_q.size() != 0) rd_req = exp_q.pop_front();
                else rd_req = 8'h00;
            end
            if (cyc == STOP_CYC && stop && exp_q.size() < DEPTH)
                exp_q.push_back(d);
            if (cyc == STOP_CYC + 1)
                check({name, " rx_valid@stop+1"}, {7'b0, rx_valid}, {7'b0, exp_q.size() != 0});
            if (rd_cycle >= 0 && cyc == rd_cycle + 1) begin
                check({name, " midframe data"}, mmio_rdata, rd_req);
                check({name, " midframe hit"}, {7'b0, mmio_hit}, 8'h01);
            end
        end
        mmio_read = 1'b0;
    endtask

    // n consecutive DATA strobes; each result compared against the scoreboard.
    task automatic burst_data(input int n, input string name);
        logic [7:0] req;
        for (int i = 0; i <= n; i++) begin
            @(posedge clock); #1;
            mmio_addr = DATA_ADDR;
            mmio_read = (i < n);
            @(negedge clock);
            if (i > 0) begin
                if (exp_q.size() != 0) req = exp_q.pop_front();
                else req = 8'h00;
                check({name, " data"}, mmio_rdata, req);
                check({name, " hit"}, {7'b0, mmio_hit}, 8'h01);
            end
        end
        mmio_read = 1'b0;
    endtask

    task automatic read_status(input logic [7:0] req, input string name);
        @(posedge clock); #1;
        mmio_addr = STATUS_ADDR;
        mmio_read = 1'b1;
        @(posedge clock); #1;
        mmio_read = 1'b0;
        @(negedge clock);
        check({name, " status"}, mmio_rdata, req);
        check({name, " status hit"}, {7'b0, mmio_hit}, 8'h01);
        @(negedge clock);
        check({name, " hit drops"}, {7'b0, mmio_hit}, 8'h00);
        check({name, " rdata holds"}, mmio_rdata, req);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'h01};
        vecs[1] = '{8'h3C, 1'b1, 8'h01};
        vecs[2] = '{8'h00, 1'b1, 8'h01};
        vecs[3] = '{8'hFF, 1'b1, 8'h01};
        vecs[4] = '{8'h55, 1'b0, 8'h08};
        vecs[5] = '{8'h81, 1'b1, 8'h01};
        vecs[6] = '{8'h5A, 1'b0, 8'h08};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset rdata", mmio_rdata, 8'h00);
        check("reset hit", {7'b0, mmio_hit}, 8'h00);
        check("reset rx_valid", {7'b0, rx_valid}, 8'h00);
        @(posedge clock); #1;
        reset = 1'b1;
        idle(4);

        // Empty reads and a non-matching address
        burst_data(1, "empty");
        read_status(8'h00, "empty");
        @(posedge clock); #1;
        mmio_addr = 16'hF012;
        mmio_read = 1'b1;
        @(posedge clock); #1;
        mmio_read = 1'b0;
        @(negedge clock);
        check("nomatch hit", {7'b0, mmio_hit}, 8'h00);

        // Table of single frames
        foreach (vecs[i]) begin
            run_frame(vecs[i].data, vecs[i].stop, -1, $sformatf("vec%0d", i));
            rx = 1'b1;
            idle(4);
            read_status(vecs[i].status, $sformatf("vec%0d", i));
            burst_data(1, $sformatf("vec%0d", i));
            @(negedge clock);
            check($sformatf("vec%0d drained rx_valid", i), {7'b0, rx_valid}, 8'h00);
        end

        // False start: short glitch must not start a frame
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            rx = 1'b0;
        end
        @(posedge clock); #1;
        rx = 1'b1;
        idle(40);
        read_status(8'h00, "glitch");
        run_frame(8'h3C, 1'b1, -1, "after_glitch");
        idle(2);
        burst_data(1, "after_glitch");

        // Framing error followed by a long break
        run_frame(8'h55, 1'b0, -1, "break");
        idle(40 * CPB);
        check("break rx_valid", {7'b0, rx_valid}, 8'h00);
        read_status(8'h08, "break first");
        read_status(8'h00, "break second");
        rx = 1'b1;
        idle(8);
        run_frame(8'h81, 1'b1, -1, "after_break");
        idle(2);
        burst_data(1, "after_break");

        // Overflow with back-to-back drain
        for (int d = 1; d <= 5; d++)
            run_frame(8'(d), 1'b1, -1, $sformatf("ovf%0d", d));
        idle(4);
        read_status(8'h07, "ovf");
        burst_data(5, "ovf");
        read_status(8'h00, "ovf after");

        // Pop on the stop-sample cycle of a frame arriving into a full FIFO
        run_frame(8'h11, 1'b1, -1, "pp_fill");
        run_frame(8'h22, 1'b1, -1, "pp_fill");
        run_frame(8'h33, 1'b1, -1, "pp_fill");
        run_frame(8'h44, 1'b1, -1, "pp_fill");
        run_frame(8'h77, 1'b1, STOP_CYC, "pushpop");
        idle(2);
        read_status(8'h03, "pushpop");
        burst_data(4, "pushpop");
        @(negedge clock);
        check("pushpop drained rx_valid", {7'b0, rx_valid}, 8'h00);

        // Reset during data bit 3 of a frame
        run_frame(8'h99, 1'b1, -1, "prereset");
        idle(2);
        read_status(8'h01, "prereset");
        for (int cyc = 0; cyc < 10 * CPB; cyc++) begin
            @(posedge clock); #1;
            rx    = frame_bit(8'hFF, 1'b1, cyc);
            reset = (cyc == 4 * CPB + CPB / 2) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (cyc == 4 * CPB + CPB / 2) exp_q.delete();
            if (cyc == 4 * CPB + CPB / 2 + 1) begin
                check("midreset rdata", mmio_rdata, 8'h00);
                check("midreset hit", {7'b0, mmio_hit}, 8'h00);
                check("midreset rx_valid", {7'b0, rx_valid}, 8'h00);
            end
        end
        rx = 1'b1;
        idle(4);
        run_frame(8'h42, 1'b1, -1, "postreset");
        idle(2);
        burst_data(2, "postreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
